keypad_emulator: RTL and testbench
==================================

Name: keypad_emulator

Overview:
Drives the row side of the 4x4 keypad matrix: a virtual keypad that answers the matrix scanner's column strobes.
- Accepts key-press requests over a valid/ready handshake.
- Presses the key for a fixed time, then releases it and enforces a gap before the next key.
- Sits on an FPGA (keys injected from a host/UART bridge) or in system benches, in place of a physical keypad.

Parameters:
- HOLD_CYCLES, 16: cycles a key is held down. Must be >= 6 so the scanner can finish one full column sweep; elaboration error otherwise.
- RELEASE_CYCLES, 4: cycles of guaranteed all-keys-up after each press; must be >= 1.
- BOUNCE_CYCLES, 3: chatter length at each edge; used only with KEYPAD_BOUNCE_EN.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- key_code  in  4  key to press, 0..11 valid (row = code[3:2], col = code[1:0]).
- key_valid  in  1  request valid.
- key_ready  out  1  emulator can accept a request.
- col  in  4  one-hot (or 1111) column strobe from the scanner.
- row  out  4  row lines back to the scanner.
- S_Row  out  1  "some key down" indication to the scanner.
- busy  out  1  a press or release is in progress.
- key_err  out  1  one-cycle pulse: rejected code (12..15).

Behaviour:
- Reset (reset=0, async):
  - state IDLE, counters 0.
  - row=0000, S_Row=0, busy=0, key_err=0, key_ready=1.
  - Handshakes are ignored while reset is low.
  - Asserting reset mid-press forces row and S_Row to 0 immediately, not at the next edge.
- FSM states and transitions:
  - IDLE: key_ready=1. Transfer happens on a rising edge with key_valid&key_ready.
    - Code <=11: latch row_sel=onehot(code[3:2]) and col_sel=onehot(code[1:0]), go to PRESS, counter=HOLD_CYCLES-1.
    - Code >=12: key_err=1 for exactly the next cycle, stay IDLE, no press.
  - PRESS: S_Row=1 (registered), busy=1. Decrement each cycle; at 0 go to RELEASE, counter=RELEASE_CYCLES-1.
  - RELEASE: row=0, S_Row=0, busy=1. Decrement; at 0 go to IDLE.
  - key_ready is 0 in PRESS and RELEASE; requests there are not accepted and must be held by the source.
- Timing:
  - S_Row is high for exactly HOLD_CYCLES cycles, starting the cycle after acceptance.
  - Next acceptance is possible at the earliest HOLD_CYCLES+RELEASE_CYCLES+1 cycles after the previous one.
- Row path (passive-matrix model):
  - In PRESS, row = row_sel when (col & col_sel) != 0, else 0000. Purely combinational from col.
  - Required because the scanner samples row in the same cycle it drives col. There is no loop, since the scanner's col depends only on its state.
  - col=1111 in PRESS yields row_sel. col=0000 yields 0000.
- Codes 12..15 never drive row 1000.

Optional Feature:
KEYPAD_BOUNCE_EN:
- Defined: for the first BOUNCE_CYCLES cycles of PRESS and of RELEASE, the pressed/released condition is gated by bit 0 of an 8-bit LFSR, so row and S_Row chatter.
  - LFSR: seed 8'hA5 at reset, taps x^8+x^6+x^5+x^4+1, advances every cycle.
  - Hold and release counts are unchanged.
- Undefined: clean edges exactly as above; the LFSR is not instantiated.

Decomposition:
- Package keypad_pkg:
  - KEY_CODE_W=4, NUM_KEYS=12, ROW_W=4, COL_W=4.
  - State enum {IDLE, PRESS, RELEASE}.
  - Functions code_to_row_sel and code_to_col_sel (one-hot decode).
- Sub-module keypad_bounce_lfsr (8-bit LFSR, enable + bit output), instantiated only under KEYPAD_BOUNCE_EN.

Test Plan:
1. Reset low for 3 cycles with col=1111 and key_valid=1 -> row=0000, S_Row=0, key_ready=1, no acceptance.
2. Key 5 with the scanner attached -> row_sel=0010, col_sel=0010. S_Row high 16 cycles. Scanner valid rises with code=5 during its column-1 scan. row returns to 0 in RELEASE.
3. Key 10 held, col driven directly: col=1111 -> row=0100; col=0100 -> row=0100; col=0001 -> row=0000; col=0000 -> row=0000.
4. key_code=13 accepted -> key_err=1 for one cycle. S_Row stays 0, busy 0, key_ready stays 1.
5. Key 3 then key 8 with key_valid held continuously -> key 8 accepted exactly 21 cycles after key 3 (16+4+1). key_ready low for 20 cycles in between.
6. Reset driven low on the 5th cycle of PRESS -> row and S_Row 0 in that same cycle. After release: IDLE, key_ready=1, no key_err.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared keypad matrix geometry, FSM state type and key-code decode helpers.
package keypad_pkg;

    localparam int KEY_CODE_W = 4;
    localparam int NUM_KEYS   = 12;
    localparam int ROW_W      = 4;
    localparam int COL_W      = 4;

    typedef enum logic [1:0] {
        IDLE,
        PRESS,
        RELEASE
    } state_t;

    function automatic logic [ROW_W-1:0] code_to_row_sel(input logic [KEY_CODE_W-1:0] code);
        logic [ROW_W-1:0] sel;
        sel = '0;
        sel[code[3:2]] = 1'b1;
        return sel;
    endfunction

    function automatic logic [COL_W-1:0] code_to_col_sel(input logic [KEY_CODE_W-1:0] code);
        logic [COL_W-1:0] sel;
        sel = '0;
        sel[code[1:0]] = 1'b1;
        return sel;
    endfunction

endpackage

// File: rtl/keypad_emulator_if.sv
// Key-press request channel: code plus valid/ready handshake from the host side.
interface keypad_emulator_if;
    import keypad_pkg::*;

    logic [KEY_CODE_W-1:0] key_code;
    logic                  key_valid;
    logic                  key_ready;

    modport master (output key_code, output key_valid, input key_ready);
    modport slave  (input key_code, input key_valid, output key_ready);

endinterface

// File: rtl/keypad_bounce_lfsr.sv
// 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1, seed 8'hA5) supplying a pseudo-random chatter bit.
module keypad_bounce_lfsr (
    input  logic clock,
    input  logic reset,
    input  logic en,
    output logic bit_out
);

    logic [7:0] q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            q <= 8'hA5;
        end else if (en) begin
            q <= {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
        end
    end

    assign bit_out = q[0];

endmodule

// File: rtl/keypad_emulator.sv
// Virtual 4x4 keypad: accepts a key code, holds it HOLD_CYCLES then forces RELEASE_CYCLES all-up; ready only in IDLE.
// Row lines answer the column strobe combinationally; KEYPAD_BOUNCE_EN adds LFSR chatter at press/release edges.
module keypad_emulator
    import keypad_pkg::*;
#(
    parameter int HOLD_CYCLES    = 16,
    parameter int RELEASE_CYCLES = 4,
    parameter int BOUNCE_CYCLES  = 3
) (
    input  logic             clock,
    input  logic             reset,
    keypad_emulator_if.slave key,
    input  logic [COL_W-1:0] col,
    output logic [ROW_W-1:0] row,
    output logic             S_Row,
    output logic             busy,
    output logic             key_err
);

    localparam int MAX_CNT = (HOLD_CYCLES > RELEASE_CYCLES) ? HOLD_CYCLES : RELEASE_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);

    generate
        if (HOLD_CYCLES < 6) begin : g_hold_chk
            $error("keypad_emulator: HOLD_CYCLES must be >= 6");
        end
        if (RELEASE_CYCLES < 1 || BOUNCE_CYCLES < 0) begin : g_rel_chk
            $error("keypad_emulator: RELEASE_CYCLES must be >= 1");
        end
    endgenerate

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [ROW_W-1:0] row_sel;
    logic [COL_W-1:0] col_sel;
    logic             press_q;
    logic             key_down;

    assign key.key_ready = (state == IDLE);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= '0;
            row_sel <= '0;
            col_sel <= '0;
            press_q <= 1'b0;
            busy    <= 1'b0;
            key_err <= 1'b0;
        end else begin
            key_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (key.key_valid) begin
                        if (key.key_code < KEY_CODE_W'(NUM_KEYS)) begin
                            row_sel <= code_to_row_sel(key.key_code);
                            col_sel <= code_to_col_sel(key.key_code);
                            cnt     <= CNT_W'(HOLD_CYCLES - 1);
                            press_q <= 1'b1;
                            busy    <= 1'b1;
                            state   <= PRESS;
                        end else begin
                            key_err <= 1'b1;
                        end
                    end
                end
                PRESS: begin
                    if (cnt == '0) begin
                        cnt     <= CNT_W'(RELEASE_CYCLES - 1);
                        press_q <= 1'b0;
                        state   <= RELEASE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RELEASE: begin
                    if (cnt == '0) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    press_q <= 1'b0;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

`ifdef KEYPAD_BOUNCE_EN
    logic chatter;
    logic in_bounce;

    keypad_bounce_lfsr u_lfsr (
        .clock   (clock),
        .reset   (reset),
        .en      (1'b1),
        .bit_out (chatter)
    );

    // Elapsed time in the current phase is the distance from the load value.
    always_comb begin
        in_bounce = 1'b0;
        if (state == PRESS) begin
            in_bounce = (CNT_W'(HOLD_CYCLES - 1) - cnt) < CNT_W'(BOUNCE_CYCLES);
        end else if (state == RELEASE) begin
            in_bounce = (CNT_W'(RELEASE_CYCLES - 1) - cnt) < CNT_W'(BOUNCE_CYCLES);
        end
    end

    assign key_down = in_bounce ? chatter : press_q;
`else
    assign key_down = press_q;
`endif

    // The scanner samples row in the same cycle it drives col, so this path stays combinational.
    assign S_Row = key_down;
    assign row   = (key_down && |(col & col_sel)) ? row_sel : '0;

endmodule

// File: tb/tb_keypad_emulator.sv
// Directed bench for keypad_emulator with a small column scanner feeding a scoreboard of expected key codes.
`timescale 1ns/1ps
module tb_keypad_emulator;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] col;
    logic [3:0] col_drv;
    logic [3:0] row;
    logic       S_Row;
    logic       busy;
    logic       key_err;

    logic       scan_en;
    logic [1:0] scan_idx;
    logic       held;
    logic       det_vld;
    logic [3:0] det_code;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int exp_q[$];

    keypad_emulator_if kif();

    keypad_emulator dut (
        .clock   (clock),
        .reset   (reset),
        .key     (kif),
        .col     (col),
        .row     (row),
        .S_Row   (S_Row),
        .busy    (busy),
        .key_err (key_err)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    assign col = scan_en ? (4'b0001 << scan_idx) : col_drv;

    function automatic logic [1:0] row_idx(input logic [3:0] r);
        return r[3] ? 2'd3 : r[2] ? 2'd2 : r[1] ? 2'd1 : 2'd0;
    endfunction

    // Scanner: sweeps one column per cycle, reports a key once per S_Row assertion.
    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            scan_idx <= 2'd0;
            held     <= 1'b0;
            det_vld  <= 1'b0;
            det_code <= 4'd0;
        end else begin
            scan_idx <= scan_idx + 2'd1;
            det_vld  <= 1'b0;
            if (!S_Row) begin
                held <= 1'b0;
            end else if (scan_en && row != 4'b0000 && !held) begin
                held     <= 1'b1;
                det_vld  <= 1'b1;
                det_code <= {row_idx(row), scan_idx};
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
        if (det_vld) begin
            chk("scan_pending", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) chk("scan_code", 32'(det_code), 32'(exp_q.pop_front()));
        end
    endtask

    task automatic press(input logic [3:0] c);
        tick();
        kif.key_code  = c;
        kif.key_valid = 1'b1;
        tick();
        kif.key_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 60 && !kif.key_ready; i++) tick();
        chk("idle_reached", 32'(kif.key_ready), 32'd1);
    endtask

    initial begin
        int n;
        int low;
        int t3;
        int t8;
        kif.key_code  = 4'd5;
        kif.key_valid = 1'b1;
        col_drv       = 4'b1111;
        scan_en       = 1'b0;

        // Reset held with a pending request and all columns strobed.
        repeat (3) begin
            tick();
            chk("rst_row",   32'(row),           32'h0);
            chk("rst_srow",  32'(S_Row),         32'd0);
            chk("rst_ready", 32'(kif.key_ready), 32'd1);
            chk("rst_busy",  32'(busy),          32'd0);
        end
        kif.key_valid = 1'b0;
        reset = 1'b1;
        tick();
        chk("post_rst_busy", 32'(busy), 32'd0);

        // Key 5 seen by the scanner on column 1.
        scan_en = 1'b1;
        exp_q.push_back(5);
        press(4'd5);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if (S_Row) n++;
            else if (n != 0) break;
            tick();
        end
        chk("k5_srow_len", 32'(n),    32'd16);
        chk("k5_rel_row",  32'(row),  32'h0);
        chk("k5_rel_busy", 32'(busy), 32'd1);
        wait_idle();
        chk("k5_scan_done", 32'(exp_q.size()), 32'd0);

        // Key 10 with directly driven columns.
        scan_en = 1'b0;
        col_drv = 4'b1111;
        press(4'd10);
        #1 chk("k10_c1111", 32'(row), 32'h4);
        tick(); col_drv = 4'b0100;
        #1 chk("k10_c0100", 32'(row), 32'h4);
        tick(); col_drv = 4'b0001;
        #1 chk("k10_c0001", 32'(row), 32'h0);
        tick(); col_drv = 4'b0000;
        #1 chk("k10_c0000", 32'(row), 32'h0);
        chk("k10_ready", 32'(kif.key_ready), 32'd0);
        chk("k10_busy",  32'(busy),          32'd1);
        wait_idle();

        // Invalid code 13.
        col_drv = 4'b1111;
        press(4'd13);
        chk("k13_err",   32'(key_err),       32'd1);
        chk("k13_srow",  32'(S_Row),         32'd0);
        chk("k13_busy",  32'(busy),          32'd0);
        chk("k13_ready", 32'(kif.key_ready), 32'd1);
        chk("k13_row",   32'(row),           32'h0);
        tick();
        chk("k13_err_off", 32'(key_err), 32'd0);

        // Back-to-back keys 3 and 8 with valid held throughout.
        scan_en = 1'b1;
        tick();
        kif.key_code  = 4'd3;
        kif.key_valid = 1'b1;
        t3 = cyc + 1;
        exp_q.push_back(3);
        tick();
        kif.key_code = 4'd8;
        exp_q.push_back(8);
        low = 0;
        t8  = 0;
        for (int i = 0; i < 60; i++) begin
            if (kif.key_ready) begin
                t8 = cyc + 1;
                break;
            end
            low++;
            tick();
        end
        tick();
        kif.key_valid = 1'b0;
        chk("b2b_gap",       32'(t8 - t3), 32'd21);
        chk("b2b_ready_low", 32'(low),     32'd20);
        tick();
        wait_idle();
        chk("b2b_scan_done", 32'(exp_q.size()), 32'd0);

        // Reset in the fifth PRESS cycle clears row/S_Row without waiting for an edge.
        scan_en = 1'b0;
        col_drv = 4'b1111;
        press(4'd10);
        repeat (4) tick();
        chk("mid_pre_srow", 32'(S_Row), 32'd1);
        chk("mid_pre_row",  32'(row),   32'h4);
        reset = 1'b0;
        #1;
        chk("mid_rst_row",  32'(row),   32'h0);
        chk("mid_rst_srow", 32'(S_Row), 32'd0);
        chk("mid_rst_busy", 32'(busy),  32'd0);
        tick();
        tick();
        reset = 1'b1;
        tick();
        chk("mid_post_busy",  32'(busy),          32'd0);
        chk("mid_post_ready", 32'(kif.key_ready), 32'd1);
        chk("mid_post_err",   32'(key_err),       32'd0);
        chk("mid_post_srow",  32'(S_Row),         32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
